// File: rtl/sram_128b_w16_arbiter_pkg.sv
// Shared SRAM macro constants for the 128b x 16 arbiter.
// Pin polarities of the single-port macro are also collected here.
package sram_128b_w16_arbiter_pkg;
  localparam int   SRAM_DEPTH = 16;
  localparam int   SRAM_AW    = $clog2(SRAM_DEPTH);
  localparam int   SRAM_DW    = 128;
  localparam logic OP_READ    = 1'b0;
  localparam logic OP_WRITE   = 1'b1;
  localparam logic CEN_ON     = 1'b0;
  localparam logic WEN_WR     = 1'b0;

  // Pointer width that stays legal when only one requester exists.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_128b_w16_arbiter_rr.sv
// Combinational round-robin picker: first valid at or after rr_ptr, wrapping.
module sram_128b_w16_arbiter_rr #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);
  int            sum;
  logic [PW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = int'(rr_ptr) + k;
      if (sum >= N) sum = sum - N;
      idx = PW'(sum);
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_128b_w16_arbiter.sv
// Round-robin sharing of one single-port 128b x 16 SRAM between NUM_REQ clients;
// reads return one cycle later tagged with the issuing requester index.
module sram_128b_w16_arbiter
  import sram_128b_w16_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [SRAM_AW*NUM_REQ-1:0] req_addr,
  input  logic [SRAM_DW*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [SRAM_DW-1:0]         rsp_data,
  output logic                       sram_CEN,
  output logic                       sram_WEN,
  output logic [SRAM_AW-1:0]         sram_A,
  output logic [SRAM_DW-1:0]         sram_D,
  input  logic [SRAM_DW-1:0]         sram_Q
);
  localparam int PW = ptr_w(NUM_REQ);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } rsp_t;

  logic [NUM_REQ-1:0][SRAM_AW-1:0] addr_v;
  logic [NUM_REQ-1:0][SRAM_DW-1:0] wdata_v;
  logic [NUM_REQ-1:0]              valid_g;
  logic [NUM_REQ-1:0]              grant;
  logic [PW-1:0]                   g_idx;
  logic                            any_grant;
  logic [PW-1:0]                   rr_ptr;
  logic                            op;
  rsp_t                            rsp_q;

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;
  // Masking the requests during reset keeps the SRAM idle and ready low.
  assign valid_g = reset ? '0 : req_valid;

  sram_128b_w16_arbiter_rr #(.N(NUM_REQ), .PW(PW)) u_rr (
    .valid     (valid_g),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (g_idx),
    .any_grant (any_grant)
  );

  assign op        = any_grant ? req_we[g_idx] : OP_READ;
  assign req_ready = grant;
  assign sram_CEN  = any_grant ? CEN_ON : ~CEN_ON;
  assign sram_WEN  = (any_grant && op == OP_WRITE) ? WEN_WR : ~WEN_WR;
  assign sram_A    = any_grant ? addr_v[g_idx]  : '0;
  assign sram_D    = any_grant ? wdata_v[g_idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      rsp_q  <= '0;
    end else begin
      if (any_grant)
        rr_ptr <= (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
      rsp_q.vld <= any_grant && (op == OP_READ);
      rsp_q.id  <= ID_W'(g_idx);
    end
  end

  assign rsp_valid = rsp_q.vld;
  assign rsp_id    = rsp_q.id;
  assign rsp_data  = sram_Q;
endmodule

// File: tb/tb_sram_128b_w16_arbiter.sv
// Directed bench: SRAM macro model, round-robin/memory reference model with
// per-cycle compare, plus hand-computed literal expectations.
module tb_sram_128b_w16_arbiter;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_we, req_ready;
  logic [7:0]   req_addr;
  logic [255:0] req_wdata;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [127:0] rsp_data;
  logic         sram_CEN, sram_WEN;
  logic [3:0]   sram_A;
  logic [127:0] sram_D, sram_Q;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit done     = 0;

  always #5 clk = ~clk;

  sram_128b_w16_arbiter #(.NUM_REQ(2), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .sram_CEN(sram_CEN), .sram_WEN(sram_WEN), .sram_A(sram_A),
    .sram_D(sram_D), .sram_Q(sram_Q)
  );

  function automatic logic [127:0] pre(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  // SRAM macro: samples pins on posedge, Q updates after a read.
  logic [127:0] mem [16];
  logic [127:0] sram_q;
  initial for (int i = 0; i < 16; i++) mem[i] = pre(i);
  always @(posedge clk)
    if (!sram_CEN) begin
      if (!sram_WEN) mem[sram_A] <= sram_D;
      else           sram_q      <= mem[sram_A];
    end
  assign sram_Q = sram_q;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference model: expected grant, memory image, pending response.
  int           m_ptr    = 0;
  logic [127:0] m_mem [16];
  bit           m_rsp_v  = 0;
  int           m_rsp_id = 0;
  logic [127:0] m_rsp_d;
  initial for (int i = 0; i < 16; i++) m_mem[i] = pre(i);

  function automatic int pick(input logic [1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    int a;
    if (reset) begin
      m_ptr   = 0;
      m_rsp_v = 0;
    end else begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        a = int'(req_addr[4*g +: 4]);
        if (req_we[g]) m_mem[a] = req_wdata[128*g +: 128];
        m_rsp_v  = !req_we[g];
        m_rsp_id = g;
        m_rsp_d  = m_mem[a];
        m_ptr    = (g + 1) % N;
      end else m_rsp_v = 0;
    end
  end

  always @(negedge clk) if (!done) begin
    int g;
    g = reset ? -1 : pick(req_valid, m_ptr);
    chk("ready", 128'(req_ready), (g < 0) ? 128'd0 : 128'(2'b01 << g));
    chk("cen", 128'(sram_CEN), 128'(g < 0));
    if (g >= 0) begin
      chk("wen", 128'(sram_WEN), 128'(!req_we[g]));
      chk("addr", 128'(sram_A), 128'(req_addr[4*g +: 4]));
      chk("wdata", sram_D, req_wdata[128*g +: 128]);
    end else begin
      chk("idle_addr", 128'(sram_A), 128'd0);
      chk("idle_wdata", sram_D, 128'd0);
      if (reset) chk("rst_wen", 128'(sram_WEN), 128'd1);
    end
    chk("rsp_valid", 128'(rsp_valid), 128'(m_rsp_v));
    if (m_rsp_v) begin
      chk("rsp_id", 128'(rsp_id), 128'(m_rsp_id));
      chk("rsp_data", rsp_data, m_rsp_d);
    end
  end

  task automatic step(input logic rst, input logic [1:0] v, input logic [1:0] we,
                      input logic [3:0] a0, input logic [3:0] a1,
                      input logic [127:0] d0, input logic [127:0] d1);
    @(posedge clk); #1;
    reset = rst; req_valid = v; req_we = we;
    req_addr = {a1, a0}; req_wdata = {d1, d0};
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] a5;
    logic [127:0] e;
    a5 = {16{8'hA5}};
    reset = 1'b1; req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    repeat (3) begin
      @(negedge clk);
      chk("lit_rst_ready", 128'(req_ready), 128'd0);
      chk("lit_rst_cen", 128'(sram_CEN), 128'd1);
    end
    // release: first grant must be requester 0
    step(0, 2'b11, 2'b00, 4'd0, 4'd0, '0, '0);
    chk("lit_first_grant", 128'(req_ready), 128'(2'b01));
    step(0, 2'b00, 2'b00, 4'd0, 4'd0, '0, '0);
    chk("lit_first_rsp", rsp_data, pre(0));

    // write then read same address from the other requester
    step(0, 2'b01, 2'b01, 4'd5, 4'd0, a5, '0);
    chk("lit_wr_grant", 128'(req_ready), 128'(2'b01));
    step(0, 2'b10, 2'b00, 4'd0, 4'd5, '0, '0);
    chk("lit_rd_grant", 128'(req_ready), 128'(2'b10));
    step(0, 2'b00, 2'b00, 4'd0, 4'd0, '0, '0);
    chk("lit_raw_valid", 128'(rsp_valid), 128'd1);
    chk("lit_raw_id", 128'(rsp_id), 128'd1);
    chk("lit_raw_data", rsp_data, a5);

    // both reading for 8 cycles: grants alternate, responses follow
    for (int k = 0; k < 8; k++) begin
      step(0, 2'b11, 2'b00, 4'd0, 4'd15, '0, '0);
      chk("lit_alt_ready", 128'(req_ready), (k % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
      if (k > 0) begin
        chk("lit_alt_id", 128'(rsp_id), 128'((k - 1) % 2));
        chk("lit_alt_data", rsp_data, ((k - 1) % 2 == 0) ? pre(0) : pre(15));
      end
    end
    step(0, 2'b00, 2'b00, 4'd0, 4'd0, '0, '0);
    chk("lit_alt_last", rsp_data, pre(15));

    // requester 1 alone, then both: pointer wrapped back to 0
    repeat (4) begin
      step(0, 2'b10, 2'b00, 4'd0, 4'd3, '0, '0);
      chk("lit_solo_ready", 128'(req_ready), 128'(2'b10));
    end
    step(0, 2'b11, 2'b00, 4'd1, 4'd3, '0, '0);
    chk("lit_wrap_ready", 128'(req_ready), 128'(2'b01));
    step(0, 2'b11, 2'b00, 4'd1, 4'd3, '0, '0);
    chk("lit_wrap_next", 128'(req_ready), 128'(2'b10));

    // read granted (pointer moves to 1), then reset drops the response
    step(0, 2'b01, 2'b00, 4'd7, 4'd0, '0, '0);
    step(1, 2'b00, 2'b00, 4'd0, 4'd0, '0, '0);
    step(1, 2'b00, 2'b00, 4'd0, 4'd0, '0, '0);
    chk("lit_rst_drop", 128'(rsp_valid), 128'd0);
    step(0, 2'b11, 2'b00, 4'd2, 4'd2, '0, '0);
    chk("lit_rst_ptr", 128'(req_ready), 128'(2'b01));

    // idle gaps
    step(0, 2'b00, 2'b00, 4'd0, 4'd0, '0, '0);
    repeat (3) begin
      step(0, 2'b00, 2'b11, 4'd9, 4'd9, a5, a5);
      chk("lit_idle_cen", 128'(sram_CEN), 128'd1);
      chk("lit_idle_rsp", 128'(rsp_valid), 128'd0);
    end

    // read back all addresses with idle cycles in between
    for (int i = 0; i < 16; i++) begin
      step(0, 2'b01, 2'b00, 4'(i), 4'd0, '0, '0);
      step(0, 2'b00, 2'b00, 4'd0, 4'd0, '0, '0);
      e = (i == 5) ? a5 : pre(i);
      chk("lit_rb_valid", 128'(rsp_valid), 128'd1);
      chk("lit_rb_data", rsp_data, e);
    end

    done = 1;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
